// File: rtl/pzbcm_sram_multi_fifo_pkg.sv
// Shared sizing helpers for the multi-channel SRAM FIFO.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package pzbcm_sram_multi_fifo_pkg;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single-channel instance still needs a 1-bit select port.
    function automatic int channel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic bit read_latency_legal(input int latency);
        return (latency == 1) || (latency == 2);
    endfunction

endpackage

// File: rtl/pzbcm_sram_multi_fifo_if.sv
// Push/pop/response bundle plus per-channel clear, flags and occupancy.
// Latency: n/a (wires only).
// Backpressure: pop gated by o_pop_ack; push silently dropped when full or cleared.
interface pzbcm_sram_multi_fifo_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 64
);
    import pzbcm_sram_multi_fifo_pkg::*;

    localparam int CHW = channel_width(CHANNELS);
    localparam int CW  = count_width(DEPTH);

    logic [CHANNELS-1:0]         i_clear;
    logic                        i_push;
    logic [CHW-1:0]              i_push_channel;
    logic [WIDTH-1:0]            i_data;
    logic                        i_pop;
    logic [CHW-1:0]              i_pop_channel;
    logic                        o_pop_ack;
    logic                        o_valid;
    logic [CHW-1:0]              o_channel;
    logic [WIDTH-1:0]            o_data;
    logic [CHANNELS-1:0]         o_empty;
    logic [CHANNELS-1:0]         o_almost_full;
    logic [CHANNELS-1:0]         o_full;
    logic [CHANNELS-1:0][CW-1:0] o_word_count;

    modport slave (
        input  i_clear, i_push, i_push_channel, i_data, i_pop, i_pop_channel,
        output o_pop_ack, o_valid, o_channel, o_data,
        output o_empty, o_almost_full, o_full, o_word_count
    );

    modport master (
        output i_clear, i_push, i_push_channel, i_data, i_pop, i_pop_channel,
        input  o_pop_ack, o_valid, o_channel, o_data,
        input  o_empty, o_almost_full, o_full, o_word_count
    );

endinterface

// File: rtl/pzbcm_sram_multi_fifo_channel_ctrl.sv
// One channel's write/read pointers, occupancy count and status flags.
// Latency: flags and count update one cycle after the accepted push/pop/clear.
// Backpressure: push refused when full or clearing; pop refused when empty or clearing.
// Ports: i_push_req/i_pop_req are already qualified by channel select;
//        o_push_ok/o_pop_ok report acceptance; o_wp/o_rp are in-region word offsets.
module pzbcm_sram_multi_fifo_channel_ctrl
    import pzbcm_sram_multi_fifo_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int THRESHOLD = DEPTH
)(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clear,
    input  logic                          i_push_req,
    input  logic                          i_pop_req,
    output logic                          o_push_ok,
    output logic                          o_pop_ok,
    output logic [$clog2(DEPTH)-1:0]      o_wp,
    output logic [$clog2(DEPTH)-1:0]      o_rp,
    output logic [count_width(DEPTH)-1:0] o_count,
    output logic                          o_empty,
    output logic                          o_almost_full,
    output logic                          o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(THRESHOLD);

    logic [PW-1:0] wp_d, wp_q, rp_d, rp_q;
    logic [CW-1:0] count_d, count_q;

    // Flags come from the registered count only, so a same-cycle push can
    // never make an empty channel poppable.
    assign o_empty       = (count_q == '0);
    assign o_full        = (count_q == FULL_LEVEL);
    assign o_almost_full = (count_q >= AF_LEVEL);
    assign o_push_ok     = i_push_req && !o_full && !i_clear;
    assign o_pop_ok      = i_pop_req && !o_empty && !i_clear;
    assign o_wp          = wp_q;
    assign o_rp          = rp_q;
    assign o_count       = count_q;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (i_clear) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow is the wrap.
            if (o_push_ok) wp_d = wp_q + PW'(1);
            if (o_pop_ok)  rp_d = rp_q + PW'(1);
            case ({o_push_ok, o_pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pzbcm_sram_multi_fifo.sv
// CHANNELS independent FIFOs sharing one memory, each in a fixed DEPTH-word region.
// Latency: read data READ_LATENCY (1 or 2) cycles after o_pop_ack.
// Backpressure: none on the response path; pops gated by o_pop_ack, pushes dropped when full.
// Ports: i_clk, i_rst_n (async active-low), fifo_if (slave side of the bundle).
module pzbcm_sram_multi_fifo
    import pzbcm_sram_multi_fifo_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 64,
    parameter int THRESHOLD    = DEPTH,
    parameter int READ_LATENCY = 1
)(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    pzbcm_sram_multi_fifo_if.slave fifo_if
);
    localparam int CHW = channel_width(CHANNELS);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = count_width(DEPTH);
    localparam int AW  = CHW + PW;

    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_read_latency
        $error("pzbcm_sram_multi_fifo: READ_LATENCY must be 1 or 2");
    end

    logic [CHANNELS-1:0]         push_ok, pop_ok;
    logic [CHANNELS-1:0]         empty, almost_full, full;
    logic [CHANNELS-1:0][CW-1:0] word_count;
    logic [PW-1:0]               wp [CHANNELS];
    logic [PW-1:0]               rp [CHANNELS];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pzbcm_sram_multi_fifo_channel_ctrl #(
            .DEPTH     (DEPTH),
            .THRESHOLD (THRESHOLD)
        ) u_ctrl (
            .i_clk         (i_clk),
            .i_rst_n       (i_rst_n),
            .i_clear       (fifo_if.i_clear[c]),
            .i_push_req    (fifo_if.i_push && (fifo_if.i_push_channel == CHW'(c))),
            .i_pop_req     (fifo_if.i_pop && (fifo_if.i_pop_channel == CHW'(c))),
            .o_push_ok     (push_ok[c]),
            .o_pop_ok      (pop_ok[c]),
            .o_wp          (wp[c]),
            .o_rp          (rp[c]),
            .o_count       (word_count[c]),
            .o_empty       (empty[c]),
            .o_almost_full (almost_full[c]),
            .o_full        (full[c])
        );
    end

    assign fifo_if.o_empty       = empty;
    assign fifo_if.o_almost_full = almost_full;
    assign fifo_if.o_full        = full;
    assign fifo_if.o_word_count  = word_count;
    assign fifo_if.o_pop_ack     = |pop_ok;

    // Region base c*DEPTH plus offset is a plain concatenation since the
    // offset is always below DEPTH.
    logic          wr_en;
    logic [AW-1:0] waddr, raddr;
    assign wr_en = |push_ok;
    assign waddr = {fifo_if.i_push_channel, wp[fifo_if.i_push_channel]};
    assign raddr = {fifo_if.i_pop_channel, rp[fifo_if.i_pop_channel]};

    // Contents are deliberately not reset. A pop never targets the slot
    // being written in the same cycle because pops only see registered counts.
    logic [WIDTH-1:0] mem [CHANNELS*DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[waddr] <= fifo_if.i_data;
    end

    // Read response pipeline: stage 0 is the memory output register.
    logic [READ_LATENCY-1:0]            vld_d, vld_q;
    logic [READ_LATENCY-1:0][CHW-1:0]   chn_d, chn_q;
    logic [READ_LATENCY-1:0][WIDTH-1:0] dat_d, dat_q;

    always_comb begin
        vld_d    = vld_q;
        chn_d    = chn_q;
        dat_d    = dat_q;
        vld_d[0] = fifo_if.o_pop_ack;
        chn_d[0] = fifo_if.i_pop_channel;
        if (fifo_if.o_pop_ack) dat_d[0] = mem[raddr];
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            chn_d[i] = chn_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    // Reset drops in-flight reads; the data path needs no reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            chn_q <= '0;
        end else begin
            vld_q <= vld_d;
            chn_q <= chn_d;
        end
    end

    always_ff @(posedge i_clk) begin
        dat_q <= dat_d;
    end

    assign fifo_if.o_valid   = vld_q[READ_LATENCY-1];
    assign fifo_if.o_channel = chn_q[READ_LATENCY-1];
    assign fifo_if.o_data    = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_pzbcm_sram_multi_fifo.sv
// Randomized and directed bench for the multi-channel SRAM FIFO, both read latencies.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_pzbcm_sram_multi_fifo;
    localparam int CH    = 4;
    localparam int W     = 32;
    localparam int DEPTH = 64;
    localparam int THR   = 60;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] clear = '0;
    logic          push = 1'b0;
    logic [1:0]    push_ch = '0;
    logic [W-1:0]  data = '0;
    logic          pop = 1'b0;
    logic [1:0]    pop_ch = '0;

    always #5 clk = ~clk;

    pzbcm_sram_multi_fifo_if #(.CHANNELS(CH), .WIDTH(W), .DEPTH(DEPTH)) if1 ();
    pzbcm_sram_multi_fifo_if #(.CHANNELS(CH), .WIDTH(W), .DEPTH(DEPTH)) if2 ();

    assign if1.i_clear = clear;  assign if2.i_clear = clear;
    assign if1.i_push = push;    assign if2.i_push = push;
    assign if1.i_push_channel = push_ch; assign if2.i_push_channel = push_ch;
    assign if1.i_data = data;    assign if2.i_data = data;
    assign if1.i_pop = pop;      assign if2.i_pop = pop;
    assign if1.i_pop_channel = pop_ch;   assign if2.i_pop_channel = pop_ch;

    pzbcm_sram_multi_fifo #(.CHANNELS(CH), .WIDTH(W), .DEPTH(DEPTH), .THRESHOLD(THR),
                            .READ_LATENCY(1)) u_dut_rl1 (
        .i_clk(clk), .i_rst_n(rst_n), .fifo_if(if1));
    pzbcm_sram_multi_fifo #(.CHANNELS(CH), .WIDTH(W), .DEPTH(DEPTH), .THRESHOLD(THR),
                            .READ_LATENCY(2)) u_dut_rl2 (
        .i_clk(clk), .i_rst_n(rst_n), .fifo_if(if2));

    typedef struct {
        int          due;
        int          ch;
        logic [31:0] d;
    } resp_t;

    logic [31:0] mq [CH][$];   // reference contents per channel, head = oldest
    resp_t       rq [2][$];    // expected responses per DUT, ordered by due cycle
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_empty_rl1", if1.o_empty, 4'hF);
        chk("rst_empty_rl2", if2.o_empty, 4'hF);
        chk("rst_full_rl1", if1.o_full, 0);
        chk("rst_full_rl2", if2.o_full, 0);
        chk("rst_af_rl1", if1.o_almost_full, 0);
        chk("rst_af_rl2", if2.o_almost_full, 0);
        chk("rst_wc_rl1", if1.o_word_count, 0);
        chk("rst_wc_rl2", if2.o_word_count, 0);
        chk("rst_valid_rl1", if1.o_valid, 0);
        chk("rst_valid_rl2", if2.o_valid, 0);
    endtask

    // Compare DUT state against the model at the negedge, then advance the model
    // by the transfer that the coming posedge will perform.
    task automatic check_and_model();
        logic          exp_ack, push_acc, exp_v;
        logic [CH-1:0] e_empty, e_full, e_af;
        logic [CH-1:0][6:0] e_wc;
        logic          got_v [2];
        logic [1:0]    got_c [2];
        logic [31:0]   got_d [2];
        logic [31:0]   d0;

        // Acceptance is decided on occupancy before this cycle's transfers.
        exp_ack  = pop && (mq[pop_ch].size() != 0) && !clear[pop_ch];
        push_acc = push && (mq[push_ch].size() < DEPTH) && !clear[push_ch];
        for (int c = 0; c < CH; c++) begin
            e_empty[c] = (mq[c].size() == 0);
            e_full[c]  = (mq[c].size() == DEPTH);
            e_af[c]    = (mq[c].size() >= THR);
            e_wc[c]    = 7'(mq[c].size());
        end
        chk("pop_ack_rl1", if1.o_pop_ack, exp_ack);
        chk("pop_ack_rl2", if2.o_pop_ack, exp_ack);
        chk("empty_rl1", if1.o_empty, e_empty);
        chk("empty_rl2", if2.o_empty, e_empty);
        chk("full_rl1", if1.o_full, e_full);
        chk("full_rl2", if2.o_full, e_full);
        chk("almost_full_rl1", if1.o_almost_full, e_af);
        chk("almost_full_rl2", if2.o_almost_full, e_af);
        chk("word_count_rl1", if1.o_word_count, e_wc);
        chk("word_count_rl2", if2.o_word_count, e_wc);

        got_v[0] = if1.o_valid; got_c[0] = if1.o_channel; got_d[0] = if1.o_data;
        got_v[1] = if2.o_valid; got_c[1] = if2.o_channel; got_d[1] = if2.o_data;
        for (int r = 0; r < 2; r++) begin
            exp_v = (rq[r].size() != 0) && (rq[r][0].due == cyc);
            chk(r == 0 ? "valid_rl1" : "valid_rl2", got_v[r], exp_v);
            if (exp_v) begin
                chk(r == 0 ? "channel_rl1" : "channel_rl2", got_c[r], rq[r][0].ch);
                chk(r == 0 ? "data_rl1" : "data_rl2", got_d[r], rq[r][0].d);
                void'(rq[r].pop_front());
            end
        end

        if (exp_ack) begin
            d0 = mq[pop_ch].pop_front();
            rq[0].push_back('{cyc + 1, int'(pop_ch), d0});
            rq[1].push_back('{cyc + 2, int'(pop_ch), d0});
        end
        if (push_acc) mq[push_ch].push_back(data);
        for (int c = 0; c < CH; c++) if (clear[c]) mq[c].delete();
        cyc++;
    endtask

    // Called #1 after a posedge; returns #1 after the next posedge.
    task automatic step(input logic p, input int pc, input logic [31:0] d,
                        input logic q, input int qc, input logic [CH-1:0] clr);
        push = p; push_ch = 2'(pc); data = d;
        pop = q; pop_ch = 2'(qc); clear = clr;
        @(negedge clk);
        check_and_model();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        push = 0; pop = 0; clear = '0;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        for (int c = 0; c < CH; c++) mq[c].delete();
        rq[0].delete();
        rq[1].delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill channel 2 to the brim, then one push too many.
        for (int i = 0; i < DEPTH + 1; i++) step(1, 2, 32'h2000 + i, 0, 0, '0);
        idle(1);
        step(0, 0, 0, 0, 0, 4'b0100);

        // Interleaved pushes to ch0/ch1, pops alternating ch1/ch0.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'hA0 + i, 0, 0, '0);
            step(1, 1, 32'hB0 + i, 0, 0, '0);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 1, '0);
            step(0, 0, 0, 1, 0, '0);
        end
        idle(3);

        // Same-cycle push and pop to an empty channel: pop refused.
        step(1, 3, 32'h55, 1, 3, '0);
        step(0, 0, 0, 1, 3, '0);
        idle(3);

        // Steady state on ch1 with 5 words resident; pointers wrap several times.
        for (int i = 0; i < 5; i++) step(1, 1, 32'h1000 + i, 0, 0, '0);
        for (int i = 0; i < 200; i++) step(1, 1, $urandom, 1, 1, '0);
        idle(3);

        // Clear ch0 while its read is in flight.
        step(1, 0, 32'hC0, 0, 0, '0);
        step(1, 0, 32'hC1, 0, 0, '0);
        step(0, 0, 0, 1, 0, '0);
        step(0, 0, 0, 0, 0, 4'b0001);
        idle(4);

        // Random traffic, with a reset landing on an in-flight read midway.
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) begin
                step(1, 0, $urandom, 0, 0, '0);
                step(0, 0, 0, 1, 0, '0);
                do_reset();
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                 ($urandom_range(0, 39) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pzbcm_sram_multi_fifo.md
PZBCM_SRAM_MULTI_FIFO -- requirements
Module: pzbcm_sram_multi_fifo

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent FIFO channels sharing one memory.
REQ-002 SHALL have parameter WIDTH, default 32: data width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, power of two, at least 2: words per channel.
REQ-004 SHALL have parameter THRESHOLD, default DEPTH: per-channel almost-full level.
REQ-005 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2: memory read latency in cycles.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-007 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port i_clear, input, CHANNELS bits: per-channel synchronous clear.
REQ-009 SHALL have port i_push, input, 1 bit: write request.
REQ-010 SHALL have port i_push_channel, input, $clog2(CHANNELS) bits: write channel select.
REQ-011 SHALL have port i_data, input, WIDTH bits: write data.
REQ-012 SHALL have port i_pop, input, 1 bit: read request.
REQ-013 SHALL have port i_pop_channel, input, $clog2(CHANNELS) bits: read channel select.
REQ-014 SHALL have port o_pop_ack, output, 1 bit: read request accepted this cycle.
REQ-015 SHALL have port o_valid, output, 1 bit: read data valid.
REQ-016 SHALL have port o_channel, output, $clog2(CHANNELS) bits: channel of the returned data.
REQ-017 SHALL have port o_data, output, WIDTH bits: read data.
REQ-018 SHALL have ports o_empty, o_almost_full and o_full, output, CHANNELS bits each: per-channel flags.
REQ-019 SHALL have port o_word_count, output, CHANNELS x $clog2(DEPTH+1) bits: per-channel occupancy.

Function
REQ-020 SHALL store channel c words in the static memory region c*DEPTH .. c*DEPTH+DEPTH-1.
REQ-021 SHALL write address c*DEPTH+wp[c]; wp wraps from DEPTH-1 to 0.
REQ-022 SHALL accept a push when i_push=1 and o_full[i_push_channel]=0 and i_clear[i_push_channel]=0.
REQ-023 SHALL ignore a push that is not accepted: no write, no pointer or count change.
REQ-024 SHALL drive o_pop_ack = i_pop && !o_empty[i_pop_channel] && !i_clear[i_pop_channel], combinationally.
REQ-025 SHALL, for an acked pop, read address c*DEPTH+rp[c] and advance rp[c] with wrap.
REQ-026 SHALL assert o_valid exactly READ_LATENCY cycles after o_pop_ack, with o_channel and o_data.
REQ-027 SHALL provide no response backpressure; a response is delivered in every cycle that has a pending read.
REQ-028 SHALL sustain one push and one pop per cycle, on the same or different channels.
REQ-029 SHALL leave word_count unchanged when a push and an acked pop hit the same channel in one cycle.
REQ-030 SHALL reject a pop to an empty channel even if a push to that channel occurs in the same cycle; the data becomes poppable the next cycle.
REQ-031 SHALL compute o_empty (count==0), o_full (count==DEPTH) and o_almost_full (count>=THRESHOLD) from registered counts.
REQ-032 SHALL make each flag change visible in the cycle after the causing push or pop.
REQ-033 SHALL, on i_clear[c], zero wp[c], rp[c] and count[c] the next cycle.
REQ-034 SHALL still deliver responses already in flight for a cleared channel.
REQ-035 SHALL keep other channels unaffected by a clear.
REQ-036 SHALL never read and write the same address in one cycle, because REQ-030 guarantees it.

Reset
REQ-037 SHALL asynchronously reset all pointers and counts to 0 while i_rst_n=0.
REQ-038 SHALL reset o_empty to all-ones, o_full, o_almost_full and o_word_count to 0, and o_valid to 0.
REQ-039 SHALL drop in-flight reads on reset.
REQ-040 SHALL NOT reset memory contents; o_data is don't-care while o_valid=0.

Structure
REQ-041 SHALL take the count width, channel-index width and the READ_LATENCY legality check from package pzbcm_sram_multi_fifo_pkg.
REQ-042 SHALL implement per-channel wp/rp/count/flag logic in sub-module pzbcm_sram_multi_fifo_channel_ctrl, instantiated CHANNELS times.
REQ-043 SHALL have a top level containing the memory array, the address mux and the READ_LATENCY valid/channel pipeline.

Verification
REQ-044 SHALL cover: push 64 words to channel 2 (DEPTH=64) -> o_full[2]=1 one cycle after the 64th push; 65th push ignored; count stays 64.
REQ-045 SHALL cover: interleaved pushes A0..A3 to ch0 and B0..B3 to ch1, then pops alternating ch1/ch0 -> data returned per channel in order, o_channel correct, o_valid exactly READ_LATENCY cycles after o_pop_ack (check both latencies 1 and 2).
REQ-046 SHALL cover: ch3 empty, push 0x55 and pop ch3 in the same cycle -> o_pop_ack=0; pop next cycle returns 0x55.
REQ-047 SHALL cover: ch1 holds 5 words, continuous push and pop of ch1 for 200 cycles -> count stays 5, pointers wrap, data order preserved.
REQ-048 SHALL cover: pop ch0 issued, then i_clear[0] next cycle -> in-flight response still delivered; ch0 empty afterwards; ch1 count unchanged.
REQ-049 SHALL cover: i_rst_n low mid-traffic -> all flags at reset values immediately, no o_valid until the next accepted pop.
